// File: rtl/vpu_issue_arbiter.sv
// Round-robin share of one VPU among NUM_REQ sources: the instruction shows on vpu_inst the cycle after accept and holds until vpu_done or watchdog abort.
// A grant is offered only in IDLE; the requester holds req_valid until its one-hot req_ready, and each instruction is followed by one forced NOP cycle.
module vpu_issue_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int INST_W      = 32,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*INST_W-1:0]   req_inst,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [NUM_REQ-1:0]          req_err,
    output logic [INST_W-1:0]           vpu_inst,
    input  logic                        vpu_done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state;
    logic [OWN_W-1:0]     rr_ptr;
    logic [TIMEOUT_W-1:0] wdog;

    logic                 gnt_vld;
    logic [OWN_W-1:0]     gnt_idx;
    int                   cand;
    logic                 wdog_hit;

    // Grant is gated by reset so nothing is offered while the block is held in reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (state == S_IDLE && rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (int'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_vld && req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = OWN_W'(cand);
                end
            end
        end
        req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign wdog_hit = (TIMEOUT_CYC != 0) && (wdog == WDOG_LAST);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            vpu_inst <= '0;
            req_done <= '0;
            req_err  <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            wdog     <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        vpu_inst <= req_inst[gnt_idx*INST_W +: INST_W];
                        owner    <= gnt_idx;
                        rr_ptr   <= (gnt_idx == OWN_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        wdog     <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                    // A completion arriving on the abort cycle still counts as a completion.
                    if (vpu_done) begin
                        req_done <= NUM_REQ'(1) << owner;
                        vpu_inst <= '0;
                        state    <= S_GAP;
                    end else if (wdog_hit) begin
                        req_err  <= NUM_REQ'(1) << owner;
                        vpu_inst <= '0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_issue_arbiter.sv
// Bench for vpu_issue_arbiter: directed scenarios then random traffic, all checked cycle by cycle against a transaction-level model.
module tb_vpu_issue_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_inst;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic [W-1:0]   vpu_inst;
    logic           vpu_done;
    logic           busy;
    logic           owner;

    always #5 clk = ~clk;

    vpu_issue_arbiter #(
        .NUM_REQ    (N),
        .INST_W     (W),
        .TIMEOUT_W  (16),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_inst (req_inst),
        .req_ready(req_ready),
        .req_done (req_done),
        .req_err  (req_err),
        .vpu_inst (vpu_inst),
        .vpu_done (vpu_done),
        .busy     (busy),
        .owner    (owner)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: is an instruction in flight, is the NOP gap pending, and how long it has run.
    bit           m_act;
    bit           m_gap;
    logic [W-1:0] m_inst;
    int           m_owner;
    int           m_ptr;
    int           m_cnt;
    logic [N-1:0] m_done;
    logic [N-1:0] m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_gap = 0; m_inst = '0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_done = '0; m_err = '0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic compare_and_advance();
        int g;
        logic [N-1:0] er;
        g  = (!m_act && !m_gap && rst) ? pick(req_valid, m_ptr) : -1;
        er = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("vpu_inst",  64'(vpu_inst),  64'(m_act ? m_inst : '0));
        chk("req_done",  64'(req_done),  64'(m_done));
        chk("req_err",   64'(req_err),   64'(m_err));
        chk("busy",      64'(busy),      64'(m_act || m_gap));
        chk("owner",     64'(owner),     64'(m_owner));
        if (!rst) begin
            model_reset();
        end else begin
            m_done = '0;
            m_err  = '0;
            if (m_act) begin
                m_cnt++;
                if (vpu_done) begin
                    m_done = N'(1) << m_owner;
                    m_act = 0; m_gap = 1;
                end else if (TO != 0 && m_cnt == TO) begin
                    m_err = N'(1) << m_owner;
                    m_act = 0; m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (g >= 0) begin
                m_act   = 1;
                m_inst  = req_inst[g*W +: W];
                m_owner = g;
                m_ptr   = (g + 1) % N;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [W-1:0] i0, input logic [W-1:0] i1,
                        input logic d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_inst  = {i1, i0};
        vpu_done  = d;
        @(negedge clk);
        compare_and_advance();
    endtask

    int exp_order[5] = '{0, 1, 0, 1, 0};

    initial begin
        int n_vis;
        int got_g;
        rst = 1'b1;
        req_valid = '0;
        req_inst  = '0;
        vpu_done  = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        step(2'b11, 32'h1, 32'h2, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;

        // Single instruction held five cycles, then done pulse and a NOP gap.
        step(2'b01, 32'h1234_0001, 32'h0, 1'b0);
        n_vis = 0;
        for (int k = 0; k < 6; k++) begin
            step((k == 5) ? 2'b01 : 2'b00, 32'h1234_0001, 32'h0, 1'(k == 4));
            if (vpu_inst == 32'h1234_0001) n_vis++;
            if (k == 5) begin
                chk("t1_done", 64'(req_done), 64'(2'b01));
                chk("t1_gap_ready", 64'(req_ready), 64'(0));
            end
        end
        chk("t1_cycles", 64'(n_vis), 64'(5));

        // Watchdog abort on requester 1.
        step(2'b10, 32'h0, 32'hDEAD_0003, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(2'b00, 32'h0, 32'h0, 1'b0);
        end
        chk("t3_err", 64'(req_err), 64'(2'b10));
        chk("t3_done", 64'(req_done), 64'(0));
        chk("t3_inst", 64'(vpu_inst), 64'(0));

        // Round-robin with both requesters valid throughout.
        for (int r = 0; r < 5; r++) begin
            step(2'b11, 32'hA000_0000 + r, 32'hB000_0000 + r, 1'b0);
            got_g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
            chk("rr_order", 64'(got_g), 64'(exp_order[r]));
            step(2'b11, 32'h0, 32'h0, 1'b0);
            step(2'b11, 32'h0, 32'h0, 1'b1);
            step(2'b11, 32'h0, 32'h0, 1'b0);
        end

        // vpu_done on the same cycle the watchdog would fire.
        step(2'b01, 32'hC011_0004, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(2'b00, 32'h0, 32'h0, 1'(k == 7));
        end
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t4_done", 64'(req_done), 64'(2'b01));
        chk("t4_err", 64'(req_err), 64'(0));

        // Stray completions while idle.
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 32'h0, 32'h0, 1'b1);
            chk("stray_busy", 64'(busy), 64'(0));
        end

        // Asynchronous reset while an instruction is active.
        step(2'b01, 32'hA5A5_A5A5, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t5_active", 64'(vpu_inst), 64'(32'hA5A5_A5A5));
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t5_rst_inst", 64'(vpu_inst), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_pulse", 64'({req_done, req_err}), 64'(0));
        model_reset();
        step(2'b00, 32'h0, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b1);
        #2 rst = 1'b1;
        step(2'b11, 32'h0000_0005, 32'h1111_0005, 1'b0);
        chk("t5_grant", 64'(req_ready), 64'(2'b01));

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
